// File: rtl/rgmii_tx_rate_gen.sv
// RGMII transmit rate generator: 1G / 100M / 10M TXC and data ODDR feeds
// with a drain-and-gap sequence whenever the link speed changes.
module rgmii_tx_rate_gen #(
    parameter int DIV_100    = 5,
    parameter int DIV_10     = 50,
    parameter int BYTE_MODE  = 0,
    parameter int SWITCH_GAP = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] speed,
    input  logic [7:0] gmii_txd,
    input  logic       gmii_tx_en,
    input  logic       gmii_tx_er,
    output logic       gmii_tx_clk_en,
    output logic       txc_d1,
    output logic       txc_d2,
    output logic [3:0] td_d1,
    output logic [3:0] td_d2,
    output logic       tx_ctl_d1,
    output logic       tx_ctl_d2,
    output logic       busy
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    localparam logic [1:0] SPD_1G  = 2'b10;
    localparam logic [1:0] SPD_10M = 2'b00;

    localparam logic [7:0] DIV100_W = 8'(DIV_100);
    localparam logic [7:0] DIV10_W  = 8'(DIV_10);
    localparam logic [7:0] GAP_LAST = 8'(SWITCH_GAP - 1);
    localparam logic       BM       = (BYTE_MODE != 0);

    logic [1:0] r_state;
    logic [1:0] r_act_spd;
    logic [7:0] r_cnt;
    logic       r_nib;
    logic [7:0] r_hold_d;
    logic       r_hold_en;
    logic       r_hold_er;
    logic [7:0] r_gap_cnt;

    logic [1:0] w_spd_norm;
    logic [7:0] w_div;
    logic       w_last;
    logic       w_is_1g;

    logic [1:0] w_state_nxt;
    logic [1:0] w_spd_nxt;
    logic [7:0] w_cnt_nxt;
    logic       w_nib_nxt;
    logic [7:0] w_hold_d_nxt;
    logic       w_hold_en_nxt;
    logic       w_hold_er_nxt;
    logic [7:0] w_gap_nxt;

    logic [7:0] w_div_n;
    logic [8:0] w_h1;
    logic [8:0] w_h2;
    logic [3:0] w_nibble;

    logic       w_ce_o;
    logic       w_txc1_o;
    logic       w_txc2_o;
    logic [3:0] w_td1_o;
    logic [3:0] w_td2_o;
    logic       w_ctl1_o;
    logic       w_ctl2_o;
    logic       w_busy_o;

    assign w_spd_norm = (speed == 2'b11) ? SPD_1G : speed;
    assign w_div      = (r_act_spd == SPD_10M) ? DIV10_W : DIV100_W;
    assign w_last     = (r_cnt == w_div - 8'd1);
    assign w_is_1g    = r_act_spd[1];

    // Next-state: period counter, nibble select, hold register, switch FSM
    always_comb begin
        w_state_nxt   = r_state;
        w_spd_nxt     = r_act_spd;
        w_cnt_nxt     = r_cnt;
        w_nib_nxt     = r_nib;
        w_hold_d_nxt  = r_hold_d;
        w_hold_en_nxt = r_hold_en;
        w_hold_er_nxt = r_hold_er;
        w_gap_nxt     = r_gap_cnt;
        case (r_state)
            ST_RUN: begin
                if (w_is_1g) begin
                    w_hold_d_nxt  = gmii_txd;
                    w_hold_en_nxt = gmii_tx_en;
                    w_hold_er_nxt = gmii_tx_er;
                end else begin
                    if (gmii_tx_clk_en) begin
                        w_hold_d_nxt  = gmii_txd;
                        w_hold_en_nxt = gmii_tx_en;
                        w_hold_er_nxt = gmii_tx_er;
                    end
                    w_cnt_nxt = w_last ? 8'd0 : r_cnt + 8'd1;
                    w_nib_nxt = BM & (r_nib ^ w_last);
                end
                if (w_spd_norm != r_act_spd) begin
                    w_state_nxt = w_is_1g ? ST_GAP : ST_DRAIN;
                    w_gap_nxt   = 8'd0;
                end
            end
            ST_DRAIN: begin
                w_cnt_nxt = w_last ? 8'd0 : r_cnt + 8'd1;
                w_nib_nxt = BM & (r_nib ^ w_last);
                if (w_last) begin
                    w_state_nxt = ST_GAP;
                    w_gap_nxt   = 8'd0;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_state_nxt   = ST_RUN;
                    w_spd_nxt     = w_spd_norm;
                    w_cnt_nxt     = 8'd0;
                    w_nib_nxt     = 1'b0;
                    w_hold_d_nxt  = 8'd0;
                    w_hold_en_nxt = 1'b0;
                    w_hold_er_nxt = 1'b0;
                end else begin
                    w_gap_nxt = r_gap_cnt + 8'd1;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    assign w_div_n  = (w_spd_nxt == SPD_10M) ? DIV10_W : DIV100_W;
    assign w_h1     = {w_cnt_nxt, 1'b0};
    assign w_h2     = {w_cnt_nxt, 1'b1};
    assign w_nibble = (BM && w_nib_nxt) ? w_hold_d_nxt[7:4]
                                        : w_hold_d_nxt[3:0];

    // Output values derived from the next state so they line up with it
    always_comb begin
        w_ce_o   = 1'b0;
        w_txc1_o = 1'b0;
        w_txc2_o = 1'b0;
        w_td1_o  = 4'd0;
        w_td2_o  = 4'd0;
        w_ctl1_o = 1'b0;
        w_ctl2_o = 1'b0;
        w_busy_o = (w_state_nxt != ST_RUN);
        if (w_state_nxt != ST_GAP) begin
            if (w_spd_nxt[1]) begin
                w_ce_o   = 1'b1;
                w_txc1_o = 1'b1;
                w_td1_o  = w_hold_d_nxt[3:0];
                w_td2_o  = w_hold_d_nxt[7:4];
                w_ctl1_o = w_hold_en_nxt;
                w_ctl2_o = w_hold_en_nxt ^ w_hold_er_nxt;
            end else begin
                w_txc1_o = (w_h1 < {1'b0, w_div_n});
                w_txc2_o = (w_h2 < {1'b0, w_div_n});
                w_td1_o  = w_nibble;
                w_td2_o  = w_nibble;
                w_ctl1_o = w_txc1_o ? w_hold_en_nxt
                                    : (w_hold_en_nxt ^ w_hold_er_nxt);
                w_ctl2_o = w_txc2_o ? w_hold_en_nxt
                                    : (w_hold_en_nxt ^ w_hold_er_nxt);
                w_ce_o   = (w_state_nxt == ST_RUN)
                         && (w_cnt_nxt == w_div_n - 8'd1)
                         && (!BM || w_nib_nxt);
            end
        end
    end

    // State and output registers, cleared asynchronously by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_RUN;
            r_act_spd      <= SPD_1G;
            r_cnt          <= 8'd0;
            r_nib          <= 1'b0;
            r_hold_d       <= 8'd0;
            r_hold_en      <= 1'b0;
            r_hold_er      <= 1'b0;
            r_gap_cnt      <= 8'd0;
            gmii_tx_clk_en <= 1'b0;
            txc_d1         <= 1'b0;
            txc_d2         <= 1'b0;
            td_d1          <= 4'd0;
            td_d2          <= 4'd0;
            tx_ctl_d1      <= 1'b0;
            tx_ctl_d2      <= 1'b0;
            busy           <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_act_spd      <= w_spd_nxt;
            r_cnt          <= w_cnt_nxt;
            r_nib          <= w_nib_nxt;
            r_hold_d       <= w_hold_d_nxt;
            r_hold_en      <= w_hold_en_nxt;
            r_hold_er      <= w_hold_er_nxt;
            r_gap_cnt      <= w_gap_nxt;
            gmii_tx_clk_en <= w_ce_o;
            txc_d1         <= w_txc1_o;
            txc_d2         <= w_txc2_o;
            td_d1          <= w_td1_o;
            td_d2          <= w_td2_o;
            tx_ctl_d1      <= w_ctl1_o;
            tx_ctl_d2      <= w_ctl2_o;
            busy           <= w_busy_o;
        end
    end

endmodule

// File: tb/tb_rgmii_tx_rate_gen.sv
// Bench for rgmii_tx_rate_gen: byte-mode and nibble-mode instances
// checked cycle by cycle against a period-position reference model.
module tb_rgmii_tx_rate_gen;

    localparam int B_D100 = 5;
    localparam int B_D10  = 50;
    localparam int B_GAP  = 8;
    localparam int N_D100 = 4;
    localparam int N_D10  = 7;
    localparam int N_GAP  = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] speed = 2'b10;
    logic [7:0] gmii_txd = 8'd0;
    logic       gmii_tx_en = 1'b0;
    logic       gmii_tx_er = 1'b0;

    logic       ce_b, t1_b, t2_b, c1_b, c2_b, busy_b;
    logic [3:0] d1_b, d2_b;
    logic       ce_n, t1_n, t2_n, c1_n, c2_n, busy_n;
    logic [3:0] d1_n, d2_n;

    logic [13:0] got_b, got_n;
    assign got_b = {busy_b, ce_b, t1_b, t2_b, d1_b, d2_b, c1_b, c2_b};
    assign got_n = {busy_n, ce_n, t1_n, t2_n, d1_n, d2_n, c1_n, c2_n};

    int errors = 0;
    int checks = 0;

    logic [13:0] qb[$];
    logic [13:0] qn[$];

    rgmii_tx_rate_gen #(
        .DIV_100(B_D100), .DIV_10(B_D10),
        .BYTE_MODE(1), .SWITCH_GAP(B_GAP)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .speed(speed),
        .gmii_txd(gmii_txd), .gmii_tx_en(gmii_tx_en),
        .gmii_tx_er(gmii_tx_er), .gmii_tx_clk_en(ce_b),
        .txc_d1(t1_b), .txc_d2(t2_b), .td_d1(d1_b), .td_d2(d2_b),
        .tx_ctl_d1(c1_b), .tx_ctl_d2(c2_b), .busy(busy_b)
    );

    rgmii_tx_rate_gen #(
        .DIV_100(N_D100), .DIV_10(N_D10),
        .BYTE_MODE(0), .SWITCH_GAP(N_GAP)
    ) u_n (
        .clk(clk), .rst_n(rst_n), .speed(speed),
        .gmii_txd(gmii_txd), .gmii_tx_en(gmii_tx_en),
        .gmii_tx_er(gmii_tx_er), .gmii_tx_clk_en(ce_n),
        .txc_d1(t1_n), .txc_d2(t2_n), .td_d1(d1_n), .td_d2(d2_n),
        .tx_ctl_d1(c1_n), .tx_ctl_d2(c2_n), .busy(busy_n)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 run, 1 drain, 2 gap; pos is the position
    // inside one transfer unit (one nibble, or two nibbles in byte mode)
    int         m_mode[2];
    int         m_pos[2];
    int         m_gc[2];
    logic [1:0] m_spd[2];
    logic [7:0] m_byte[2];
    logic       m_en[2];
    logic       m_er[2];
    logic       m_ce[2];

    function automatic int p_div(int k, logic [1:0] s);
        if (s == 2'b00) return (k == 0) ? B_D10 : N_D10;
        return (k == 0) ? B_D100 : N_D100;
    endfunction

    function automatic int p_gap(int k);
        return (k == 0) ? B_GAP : N_GAP;
    endfunction

    function automatic int p_units(int k);
        return (k == 0) ? 2 : 1;
    endfunction

    function automatic void mreset(int k);
        m_mode[k] = 0;
        m_pos[k]  = 0;
        m_gc[k]   = 0;
        m_spd[k]  = 2'b10;
        m_byte[k] = 8'd0;
        m_en[k]   = 1'b0;
        m_er[k]   = 1'b0;
        m_ce[k]   = 1'b0;
    endfunction

    function automatic logic [13:0] mout(int k);
        int dv, len, c;
        logic t1, t2, ce, x;
        logic [3:0] nb;
        if (m_mode[k] == 2) return 14'b1 << 13;
        x = m_en[k] ^ m_er[k];
        if (m_spd[k] == 2'b10)
            return {1'b0, 1'b1, 1'b1, 1'b0, m_byte[k][3:0],
                    m_byte[k][7:4], m_en[k], x};
        dv  = p_div(k, m_spd[k]);
        len = dv * p_units(k);
        c   = m_pos[k] % dv;
        t1  = (2 * c) < dv;
        t2  = (2 * c + 1) < dv;
        nb  = (m_pos[k] >= dv) ? m_byte[k][7:4] : m_byte[k][3:0];
        ce  = (m_mode[k] == 0) && (m_pos[k] == len - 1);
        return {m_mode[k] == 1, ce, t1, t2, nb, nb,
                t1 ? m_en[k] : x, t2 ? m_en[k] : x};
    endfunction

    function automatic logic [13:0] mstep(int k, logic [1:0] s,
                                          logic [7:0] d, logic e,
                                          logic r);
        logic [1:0] ns;
        int dv, len;
        logic [13:0] o;
        ns  = (s == 2'b11) ? 2'b10 : s;
        dv  = p_div(k, m_spd[k]);
        len = dv * p_units(k);
        if (m_mode[k] == 0) begin
            if (m_spd[k] == 2'b10 || m_ce[k]) begin
                m_byte[k] = d;
                m_en[k]   = e;
                m_er[k]   = r;
            end
            if (m_spd[k] != 2'b10) m_pos[k] = (m_pos[k] + 1) % len;
            if (ns != m_spd[k]) begin
                m_mode[k] = (m_spd[k] == 2'b10) ? 2 : 1;
                m_gc[k]   = 0;
            end
        end else if (m_mode[k] == 1) begin
            if (m_pos[k] % dv == dv - 1) begin
                m_mode[k] = 2;
                m_gc[k]   = 0;
            end
            m_pos[k] = (m_pos[k] + 1) % len;
        end else begin
            if (m_gc[k] == p_gap(k) - 1) begin
                m_mode[k] = 0;
                m_spd[k]  = ns;
                m_pos[k]  = 0;
                m_byte[k] = 8'd0;
                m_en[k]   = 1'b0;
                m_er[k]   = 1'b0;
            end else begin
                m_gc[k] = m_gc[k] + 1;
            end
        end
        o = mout(k);
        m_ce[k] = o[12];
        return o;
    endfunction

    task automatic chk(input string nm, input logic [13:0] got,
                       input logic [13:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s t=%0t got=%h want=%h", nm, $time,
                         got, exp);
        end
    endtask

    task automatic cyc(input logic [1:0] s, input logic [7:0] d,
                       input logic e, input logic r, input logic rn);
        @(negedge clk);
        speed      = s;
        gmii_txd   = d;
        gmii_tx_en = e;
        gmii_tx_er = r;
        rst_n      = rn;
        if (!rn) begin
            #1;
            chk("rst_async_b", got_b, 14'd0);
            chk("rst_async_n", got_n, 14'd0);
            mreset(0);
            mreset(1);
            qb.push_back(14'd0);
            qn.push_back(14'd0);
        end else begin
            qb.push_back(mstep(0, s, d, e, r));
            qn.push_back(mstep(1, s, d, e, r));
        end
    endtask

    // Monitor: compare DUT outputs after each edge with queued predictions
    always @(posedge clk) begin
        #1;
        if (qb.size() > 0) chk("out_b", got_b, qb.pop_front());
        if (qn.size() > 0) chk("out_n", got_n, qn.pop_front());
    end

    initial begin
        int len;
        logic [1:0] s;
        mreset(0);
        mreset(1);
        repeat (3) cyc(2'b10, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (10) cyc(2'b10, 8'hA5, 1'b1, 1'b0, 1'b1);
        repeat (60) cyc(2'b01, $urandom, 1'b1, 1'b1, 1'b1);
        repeat (300) cyc(2'b00, 8'h3C, 1'b1, 1'b0, 1'b1);
        repeat (41) cyc(2'b01, $urandom, 1'b1, 1'b0, 1'b1);
        repeat (80) cyc(2'b00, $urandom, 1'b1, 1'b0, 1'b1);
        repeat (20) cyc(2'b11, $urandom, 1'b1, 1'b0, 1'b1);
        repeat (3) cyc(2'b00, $urandom, 1'b1, 1'b0, 1'b1);
        repeat (20) cyc(2'b10, $urandom, 1'b1, 1'b0, 1'b1);
        cyc(2'b00, 8'h11, 1'b0, 1'b0, 1'b1);
        repeat (3) cyc(2'b10, 8'h22, 1'b0, 1'b0, 1'b1);
        repeat (2) cyc(2'b10, 8'h33, 1'b0, 1'b0, 1'b0);
        repeat (10) cyc(2'b10, $urandom, 1'b1, 1'b0, 1'b1);
        for (int n = 0; n < 15000; n += len) begin
            s   = 2'($urandom_range(0, 3));
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12)
                                              : $urandom_range(20, 400);
            for (int i = 0; i < len; i++)
                cyc(s, 8'($urandom),
                    $urandom_range(0, 3) != 0,
                    $urandom_range(0, 7) == 0,
                    $urandom_range(0, 2999) != 0);
        end
        @(posedge clk);
        #2;
        checks++;
        if (qb.size() + qn.size() != 0) begin
            errors++;
            $display("FAIL drain_queue left=%0d want=0",
                     qb.size() + qn.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rgmii_tx_rate_gen.md
RGMII_TX_RATE_GEN -- requirements
Module: rgmii_tx_rate_gen

Interface
REQ-001 Parameter DIV_100, default 5: clk cycles per TXC period at 100M; legal range 2..255.
REQ-002 Parameter DIV_10, default 50: clk cycles per TXC period at 10M; legal range 2..255.
REQ-003 Parameter BYTE_MODE, default 0: 1 = 10/100 takes a full byte per enable and sends it as two nibbles; 0 = one nibble per enable from gmii_txd[3:0].
REQ-004 Parameter SWITCH_GAP, default 8: idle clk cycles inserted on a speed change; legal range 1..255.
REQ-005 Port clk, input, 1: single clock for the block (the GMII transmit clock); one clock; all logic on its rising edge.
REQ-006 Port rst_n, input, 1: reset; asynchronous assert, active-low.
REQ-007 Port speed, input, 2: 2'b10 = 1G, 2'b01 = 100M, 2'b00 = 10M, 2'b11 = 1G.
REQ-008 Ports gmii_txd (input, 8), gmii_tx_en (input, 1), gmii_tx_er (input, 1): MAC transmit data, enable and error.
REQ-009 Port gmii_tx_clk_en, output, 1: the MAC advances one data beat in each clk cycle where this is 1.
REQ-010 Ports txc_d1, txc_d2, output, 1 each: TXC values for the first and second half-cycle, driving the clock ODDR.
REQ-011 Ports td_d1 and td_d2 (output, 4 each), tx_ctl_d1 and tx_ctl_d2 (output, 1 each): data and control values for the first and second half-cycle, driving the data ODDR.
REQ-012 Port busy, output, 1: high while a speed switch is in progress.

Function
REQ-013 Every output is registered.
REQ-014 The state machine has three states: RUN, DRAIN and GAP. Active speed act_spd is a register; DIV is DIV_100 or DIV_10 according to act_spd.
REQ-015 RUN, 1G: txc_d1=1, txc_d2=0, gmii_tx_clk_en=1 every cycle; inputs in cycle n give td_d1=txd[3:0], td_d2=txd[7:4], tx_ctl_d1=en, tx_ctl_d2=en^er in cycle n+1.
REQ-016 RUN, 10/100: period counter cnt counts 0..DIV-1 and wraps to 0; half-cycle index h1=2*cnt, h2=2*cnt+1; txc_dX=1 when hX<DIV, else 0 (this gives odd-DIV duty correction).
REQ-017 RUN, 10/100: hold register (byte, en, er) loads when gmii_tx_clk_en=1; gmii_tx_clk_en=1 only in the cycle where cnt==DIV-1 and, if BYTE_MODE=1, nib_sel==1.
REQ-018 RUN, 10/100: td_d1=td_d2=current nibble (hold[3:0] when nib_sel==0, else hold[7:4]; always hold[3:0] when BYTE_MODE=0); tx_ctl_dX=en when txc_dX==1, else en^er.
REQ-019 nib_sel toggles on each cnt wrap and is held at 0 when BYTE_MODE=0; data loaded at an enable appears from the next cnt==0 for a full period (latency 1 clk after the enable).
REQ-020 Speed-change detection: in RUN, speed normalised (2'b11 treated as 2'b10) differing from act_spd sets busy=1 next cycle. At 1G go directly to GAP; at 10/100 go to DRAIN.
REQ-021 DRAIN: continue RUN behaviour with gmii_tx_clk_en forced to 0 until cnt==DIV-1, then go to GAP. Any untransmitted high nibble is discarded.
REQ-022 GAP: txc_d1=txc_d2=0, td=0, ctl=0, gmii_tx_clk_en=0 for SWITCH_GAP cycles.
REQ-023 Leaving GAP: act_spd is loaded from the currently sampled speed; cnt=0, nib_sel=0, hold cleared, busy=0, state=RUN.
REQ-024 A further speed change during DRAIN or GAP does not restart the sequence; the speed sampled at GAP exit wins.
REQ-025 A speed change is honoured regardless of gmii_tx_en; frame integrity across a switch is the MAC's responsibility.

Reset
REQ-026 While rst_n=0: all outputs are 0; state=RUN; act_spd=2'b10; cnt=0; nib_sel=0; hold=0.
REQ-027 After release: the first cycle produces 1G RUN outputs; a non-1G speed then follows REQ-020 through REQ-023.
REQ-028 rst_n assertion mid-DRAIN or mid-GAP clears all state asynchronously, within the same cycle.

Verification
REQ-029 1G: speed=2'b10, txd=8'hA5, en=1, er=0 -> next cycle td_d1=4'h5, td_d2=4'hA, ctl_d1=ctl_d2=1, txc 1/0, clk_en=1 continuously.
REQ-030 100M, DIV_100=5: TXC pattern per 5 cycles (d1,d2) = 11,11,10,00,00; clk_en high 1 cycle in 5 at cnt=4; en=1, er=1 gives ctl=1 in txc-high halves and 0 in txc-low halves.
REQ-031 10M, BYTE_MODE=1, DIV_10=50: byte 8'h3C -> nibble C for 50 cycles, then 3 for 50 cycles; clk_en asserted once per 100 cycles.
REQ-032 Switch 100M->10M at cnt=1 -> DRAIN until cnt=4, then 8 GAP cycles with all outputs 0 and busy=1, then RUN at DIV_10 with cnt=0.
REQ-033 Speed toggled 1G->10M->1G within GAP -> single GAP of SWITCH_GAP cycles, exit at 1G.
REQ-034 rst_n pulsed low mid-GAP -> outputs 0 immediately; after release, 1G RUN outputs and busy=0.
